// File: rtl/ibex_multdiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : ibex_multdiv_iter
// Purpose  : Iterative RV32M multiply/divide unit. It borrows the ALU's 32-bit
//            adder (with carry-out) for every add/subtract it performs and
//            keeps all iteration state locally.
//            - Multiply: 33-bit signed-aware shift-and-add, LSB of b first.
//            - Divide  : restoring shift-subtract, MSB of dividend first.
// Ports    : clk_i, rst_ni          clock, asynchronous active-low reset
//            en_i                   request, held until valid_o
//            op_i                   0=MUL 1=MULH 2=DIV 3=REM
//            signed_mode_i          bit0: a signed, bit1: b signed
//            op_a_i, op_b_i         operands, sampled when leaving IDLE
//            alu_adder_ext_i        ALU extended adder result
//            alu_operand_a/b_o      ALU multdiv operands
//            alu_sel_o              ALU multdiv select
//            busy_o, valid_o        status / one-cycle result strobe
//            result_o               result, meaningful while valid_o=1
// Revision : 1.0 - initial release
// ============================================================================
module ibex_multdiv_iter #(
    parameter int unsigned MD_ITERS = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [1:0]  op_i,
    input  logic [1:0]  signed_mode_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [33:0] alu_adder_ext_i,
    output logic [32:0] alu_operand_a_o,
    output logic [32:0] alu_operand_b_o,
    output logic        alu_sel_o,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o
);

    localparam int unsigned         c_CNT_W    = $clog2(MD_ITERS);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(MD_ITERS - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_INIT   = 2'd1;
    localparam logic [1:0] c_ST_ITER   = 2'd2;
    localparam logic [1:0] c_ST_FINISH = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // r_mcand : multiplicand (multiply) / divisor magnitude (divide)
    // r_shift : multiplier, becoming the low product word (multiply) /
    //           dividend, becoming the quotient (divide)
    // r_acc   : 33-bit partial product (multiply) / remainder in [31:0]
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         r_op;
    logic [1:0]         r_smode;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_mcand;
    logic [31:0]        r_shift;
    logic [32:0]        r_acc;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_valid;
    logic               r_busy;
    logic               r_alu_sel;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_sum;
    logic        w_carry;
    logic        w_last;
    logic        w_pp_sub;
    logic        w_pp_add;
    logic        w_mcand_msb;
    logic        w_y_msb;
    logic        w_t32;
    logic        w_c32;
    logic        w_t33;
    logic [31:0] w_rem_shift;
    logic        w_no_borrow;
    logic        w_sgn_a;
    logic        w_sgn_b;
    logic [31:0] w_fin_src;
    logic        w_fin_neg;
    logic        w_unused;

    assign w_sum    = alu_adder_ext_i[32:1];
    assign w_carry  = alu_adder_ext_i[33];
    assign w_unused = alu_adder_ext_i[0];
    assign w_last   = (r_cnt == '0);

    // ------------------------------------------------------------------------
    // Multiply step. The adder is 32 bits wide, the accumulator 33; the two
    // top bits of the 34-bit sum are rebuilt from the adder carry-out and the
    // sign bits of both addends. On the final step a set multiplier sign bit
    // weighs -2^31, so that partial product is subtracted instead of added.
    // ------------------------------------------------------------------------
    assign w_pp_sub    = w_last & r_smode[1] & r_shift[0];
    assign w_pp_add    = r_shift[0] & ~w_pp_sub;
    assign w_mcand_msb = r_smode[0] & r_mcand[31];
    assign w_y_msb     = w_pp_sub ? ~w_mcand_msb : (w_pp_add ? w_mcand_msb : 1'b0);
    assign w_t32       = r_acc[32] ^ w_y_msb ^ w_carry;
    assign w_c32       = (r_acc[32] & w_y_msb) | (r_acc[32] & w_carry) | (w_y_msb & w_carry);
    assign w_t33       = r_acc[32] ^ w_y_msb ^ w_c32;

    // ------------------------------------------------------------------------
    // Divide step. The shifted remainder is 33 bits; when its dropped top bit
    // (r_acc[31]) is set the trial value already exceeds any 32-bit divisor,
    // so the subtraction always succeeds regardless of the adder carry.
    // ------------------------------------------------------------------------
    assign w_rem_shift = {r_acc[30:0], r_shift[31]};
    assign w_no_borrow = w_carry | r_acc[31];

    assign w_sgn_a = r_smode[0] & r_mcand[31];
    assign w_sgn_b = r_smode[1] & r_shift[31];

    // MUL/DIV take their result from r_shift, MULH/REM from r_acc.
    assign w_fin_src = r_op[0] ? r_acc[31:0] : r_shift;
    assign w_fin_neg = r_op[1] & (r_op[0] ? r_neg_r : r_neg_q);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (en_i) begin
                    w_state_nxt = op_i[1] ? c_ST_INIT : c_ST_ITER;
                end
            end
            c_ST_INIT: begin
                if (!en_i) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (r_shift == '0) begin
                    w_state_nxt = c_ST_FINISH;
                end else begin
                    w_state_nxt = c_ST_ITER;
                end
            end
            c_ST_ITER: begin
                if (!en_i) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = c_ST_FINISH;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ALU operands: X+Y = {X,1}+{Y,0}; X-Y = {X,1}+{~Y,1}.
    always_comb begin
        alu_operand_a_o = '0;
        alu_operand_b_o = '0;
        case (r_state)
            c_ST_ITER: begin
                if (!r_op[1]) begin
                    alu_operand_a_o = {r_acc[31:0], 1'b1};
                    if (w_pp_sub) begin
                        alu_operand_b_o = {~r_mcand, 1'b1};
                    end else if (w_pp_add) begin
                        alu_operand_b_o = {r_mcand, 1'b0};
                    end else begin
                        alu_operand_b_o = {32'b0, 1'b0};
                    end
                end else begin
                    alu_operand_a_o = {w_rem_shift, 1'b1};
                    alu_operand_b_o = {~r_mcand, 1'b1};
                end
            end
            c_ST_FINISH: begin
                // 0 - src, used only when a divide result needs negating
                alu_operand_a_o = {32'b0, 1'b1};
                alu_operand_b_o = {~w_fin_src, 1'b1};
            end
            default: ;
        endcase
    end

    assign result_o  = (r_state == c_ST_FINISH) ? (w_fin_neg ? w_sum : w_fin_src) : '0;
    assign valid_o   = r_valid;
    assign busy_o    = r_busy;
    assign alu_sel_o = r_alu_sel;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= c_ST_IDLE;
            r_op      <= '0;
            r_smode   <= '0;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_shift   <= '0;
            r_acc     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_alu_sel <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_valid   <= (w_state_nxt == c_ST_FINISH);
            r_busy    <= (w_state_nxt != c_ST_IDLE);
            r_alu_sel <= (w_state_nxt == c_ST_ITER) || (w_state_nxt == c_ST_FINISH);

            case (r_state)
                c_ST_IDLE: begin
                    if (en_i) begin
                        r_op    <= op_i;
                        r_smode <= signed_mode_i;
                        r_mcand <= op_a_i;
                        r_shift <= op_b_i;
                        r_acc   <= '0;
                        r_cnt   <= c_CNT_LAST;
                    end
                end
                c_ST_INIT: begin
                    if (r_shift == '0) begin
                        // divide by zero: quotient all-ones, remainder = dividend
                        r_shift <= '1;
                        r_acc   <= {1'b0, r_mcand};
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                    end else begin
                        // dividend moves into the shifter, divisor into r_mcand
                        r_shift <= w_sgn_a ? (32'd0 - r_mcand) : r_mcand;
                        r_mcand <= w_sgn_b ? (32'd0 - r_shift) : r_shift;
                        r_acc   <= '0;
                        r_cnt   <= c_CNT_LAST;
                        r_neg_q <= w_sgn_a ^ w_sgn_b;
                        r_neg_r <= w_sgn_a;
                    end
                end
                c_ST_ITER: begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (!r_op[1]) begin
                        r_acc   <= {w_t33, w_t32, w_sum[31:1]};
                        r_shift <= {w_sum[0], r_shift[31:1]};
                    end else begin
                        r_acc   <= {1'b0, (w_no_borrow ? w_sum : w_rem_shift)};
                        r_shift <= {r_shift[30:0], w_no_borrow};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
